// File: rtl/bcd_conv_arb.sv
// Round-robin arbiter in front of one shared iterative binary-to-BCD engine.
// One request is taken per conversion. The engine runs 11 add-3/shift steps
// (double dabble) on the operand magnitude and returns a {sign, 4 BCD digits}
// result tagged with the requester index.
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   req_vld  per-requester request valid
//   req_bin  packed 11-bit two's-complement operands, requester i at [11i+10:11i]
//   req_rdy  one-hot accept (combinational, IDLE only)
//   out_vld  result valid, held until out_rdy
//   out_bcd  {sign, thousands, hundreds, tens, ones}
//   out_id   requester index of the result
//   out_rdy  downstream accept
//   busy     high whenever a job is in flight or waiting to be taken
module bcd_conv_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_vld,
  input  logic [NREQ*11-1:0]  req_bin,
  output logic [NREQ-1:0]     req_rdy,
  output logic                out_vld,
  output logic [16:0]         out_bcd,
  output logic [IDW-1:0]      out_id,
  input  logic                out_rdy,
  output logic                busy
);

  localparam int unsigned BW    = 11;  // operand width
  localparam int unsigned NDIG  = 4;   // BCD digits
  localparam int unsigned DW    = 4 * NDIG;
  localparam int unsigned ITW   = 4;   // iteration counter width
  localparam int unsigned LASTI = BW - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [IDW-1:0]   ptr, ptr_d;
  logic             sign, sign_d;
  logic [BW-1:0]    mag, mag_d;
  logic [DW-1:0]    bcd, bcd_d;
  logic [ITW-1:0]   iter, iter_d;
  logic [IDW-1:0]   id, id_d;
  logic             out_vld_d;
  logic [16:0]      out_bcd_d;
  logic [IDW-1:0]   out_id_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   scan_idx;
  logic [BW-1:0]    win_bin;
  logic [DW-1:0]    bcd_adj;

  // Round-robin scan: first set req_vld starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((32'(ptr) + k) % NREQ);
      if (!win_found && req_vld[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_bin = req_bin[BW*32'(win_idx) +: BW];

  // Accept strobe: only in IDLE and never while reset is asserted.
  always_comb begin
    req_rdy = '0;
    if (!rst && state == IDLE && win_found) begin
      req_rdy[win_idx] = 1'b1;
    end
  end

  // Double-dabble correction: any digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3)
                                                   : bcd[4*i +: 4];
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    sign_d    = sign;
    mag_d     = mag;
    bcd_d     = bcd;
    iter_d    = iter;
    id_d      = id;
    out_vld_d = out_vld;
    out_bcd_d = out_bcd;
    out_id_d  = out_id;

    case (state)
      IDLE: begin
        if (win_found) begin
          sign_d  = win_bin[BW-1];
          // Full 11-bit negate so -1024 yields magnitude 1024.
          mag_d   = win_bin[BW-1] ? (~win_bin + 11'd1) : win_bin;
          id_d    = win_idx;
          ptr_d   = win_idx;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag} << 1;
        iter_d         = iter + 4'd1;
        if (iter == ITW'(LASTI)) begin
          out_bcd_d = {sign, bcd_d};
          out_id_d  = id;
          out_vld_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= IDW'(NREQ - 1);
      sign    <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      iter    <= '0;
      id      <= '0;
      out_vld <= 1'b0;
      out_bcd <= '0;
      out_id  <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      sign    <= sign_d;
      mag     <= mag_d;
      bcd     <= bcd_d;
      iter    <= iter_d;
      id      <= id_d;
      out_vld <= out_vld_d;
      out_bcd <= out_bcd_d;
      out_id  <= out_id_d;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Testbench for bcd_conv_arb: directed vector table, multi-cycle corner
// sequences and randomized jobs against an arithmetic reference model.
module tb_bcd_conv_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_vld;
  logic [NREQ*11-1:0]  req_bin;
  logic [NREQ-1:0]     req_rdy;
  logic                out_vld;
  logic [16:0]         out_bcd;
  logic [IDW-1:0]      out_id;
  logic                out_rdy;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;
  int mptr;

  bcd_conv_arb #(.NREQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_bin (req_bin),
    .req_rdy (req_rdy),
    .out_vld (out_vld),
    .out_bcd (out_bcd),
    .out_id  (out_id),
    .out_rdy (out_rdy),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [3:0]  vld;
    logic [10:0] bin;
    logic [16:0] bcd;
    int          id;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed value -> sign-magnitude decimal digits.
  function automatic logic [16:0] ref_bcd(input logic [10:0] b);
    int v, m;
    v = int'($signed(b));
    m = (v < 0) ? -v : v;
    return {(v < 0) ? 1'b1 : 1'b0, 4'(m / 1000), 4'((m / 100) % 10),
            4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Reference: round-robin winner given the last granted index.
  function automatic int model_winner(input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(mptr + k) % 4]) return (mptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int w);
    logic [3:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic set_bins(input logic [10:0] b0, input logic [10:0] b1,
                          input logic [10:0] b2, input logic [10:0] b3);
    req_bin = {b3, b2, b1, b0};
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_vld = '0;
    out_rdy = 1'b1;
    tick();
    tick();
    req_vld = 4'hF;
    #1;
    check("rst_rdy_gated", 32'(req_rdy), 32'(0));
    req_vld = '0;
    rst     = 1'b0;
    #1;
    check("rst_out_vld", 32'(out_vld), 32'(0));
    check("rst_out_bcd", 32'(out_bcd), 32'(0));
    check("rst_out_id",  32'(out_id),  32'(0));
    check("rst_busy",    32'(busy),    32'(0));
    mptr = 3;
  endtask

  // One job from IDLE: accept, optional side pulse in SHIFT cycle 1,
  // latency check, result check, optional backpressure, handshake.
  task automatic run_job(input logic [3:0] vld, input logic [16:0] exp_bcd,
                         input int exp_id, input int hold, input logic [3:0] side,
                         input string tag);
    int          cyc;
    bit          stable;
    logic [16:0] held_bcd;
    logic [1:0]  held_id;
    out_rdy = (hold == 0);
    req_vld = vld;
    #1;
    check({tag, "_grant"}, 32'(req_rdy), 32'(onehot(exp_id)));
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    tick();
    mptr    = exp_id;
    req_vld = side;
    #1;
    check({tag, "_shift_rdy"}, 32'(req_rdy), 32'(0));
    check({tag, "_shift_busy"}, 32'(busy), 32'(1));
    cyc = 1;
    while (!out_vld && cyc < 40) begin
      tick();
      req_vld = '0;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(12));
    check({tag, "_bcd"}, 32'(out_bcd), 32'(exp_bcd));
    check({tag, "_id"}, 32'(out_id), 32'(exp_id));
    if (hold > 0) begin
      req_vld  = 4'hF;
      held_bcd = out_bcd;
      held_id  = out_id;
      stable   = 1'b1;
      repeat (hold) begin
        tick();
        if (!out_vld || out_bcd !== held_bcd || out_id !== held_id ||
            req_rdy !== 4'b0 || !busy) stable = 1'b0;
      end
      check({tag, "_hold_stable"}, 32'(stable), 32'(1));
      out_rdy = 1'b1;
    end
    tick();
    check({tag, "_post_vld"}, 32'(out_vld), 32'(0));
    check({tag, "_post_busy"}, 32'(busy), 32'(0));
    check({tag, "_post_rdy"}, 32'(req_rdy), 32'(onehot(model_winner(req_vld))));
  endtask

  vec_t tbl[7];
  int   g_cyc[8], g_id[8], o_id[8];
  int   ng, no, cnt, w;
  int   exp_rr[5];
  logic [3:0]  rv;
  logic [10:0] rb[4];
  logic [10:0] edge_vals[4];

  initial begin
    tbl[0] = '{4'b0001, 11'd1023, {1'b0, 4'h1, 4'h0, 4'h2, 4'h3}, 0};
    tbl[1] = '{4'b0100, 11'h400,  {1'b1, 4'h1, 4'h0, 4'h2, 4'h4}, 2};
    tbl[2] = '{4'b0100, 11'h7FF,  {1'b1, 4'h0, 4'h0, 4'h0, 4'h1}, 2};
    tbl[3] = '{4'b0100, 11'h000,  {1'b0, 4'h0, 4'h0, 4'h0, 4'h0}, 2};
    tbl[4] = '{4'b1111, 11'd500,  {1'b0, 4'h0, 4'h5, 4'h0, 4'h0}, 3};
    tbl[5] = '{4'b0011, 11'd999,  {1'b0, 4'h0, 4'h9, 4'h9, 4'h9}, 0};
    tbl[6] = '{4'b1010, 11'h7F6,  {1'b1, 4'h0, 4'h0, 4'h1, 4'h0}, 1};
    exp_rr = '{0, 1, 2, 3, 0};
    edge_vals = '{11'h400, 11'h3FF, 11'h7FF, 11'h000};

    req_bin = '0;
    do_reset();

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      set_bins(tbl[i].bin, tbl[i].bin, tbl[i].bin, tbl[i].bin);
      run_job(tbl[i].vld, tbl[i].bcd, tbl[i].id, 0, 4'b0, $sformatf("vec%0d", i));
    end

    // Backpressure for 20 cycles, then immediate accept of pending request
    // with a one-cycle req_vld[3] pulse during SHIFT, then ptr must be 1.
    set_bins(11'd42, 11'd1000, 11'h7C0, 11'd7);
    run_job(4'b0001, {1'b0, 4'h0, 4'h0, 4'h4, 4'h2}, 0, 20, 4'b0, "bp");
    run_job(4'hF, {1'b0, 4'h1, 4'h0, 4'h0, 4'h0}, 1, 0, 4'b1000, "pulse");
    run_job(4'hF, {1'b1, 4'h0, 4'h0, 4'h6, 4'h4}, 2, 0, 4'b0, "after_pulse");

    // Reset during the 5th SHIFT cycle discards the job.
    set_bins(11'd777, 11'd777, 11'd777, 11'd777);
    req_vld = 4'b0001;
    #1;
    check("abort_grant", 32'(req_rdy), 32'(4'b0001));
    tick();
    req_vld = '0;
    repeat (4) tick();
    rst     = 1'b1;
    req_vld = 4'hF;
    #1;
    check("abort_rst_rdy", 32'(req_rdy), 32'(0));
    tick();
    rst     = 1'b0;
    req_vld = '0;
    #1;
    check("abort_out_vld", 32'(out_vld), 32'(0));
    check("abort_out_bcd", 32'(out_bcd), 32'(0));
    check("abort_out_id",  32'(out_id),  32'(0));
    check("abort_busy",    32'(busy),    32'(0));
    cnt = 0;
    repeat (15) begin
      tick();
      if (out_vld) cnt++;
    end
    check("abort_no_out", 32'(cnt), 32'(0));
    mptr = 3;
    set_bins(11'd500, 11'd500, 11'd500, 11'd500);
    run_job(4'b1010, {1'b0, 4'h0, 4'h5, 4'h0, 4'h0}, 1, 0, 4'b0, "post_abort");

    // Round robin with all requesters held valid.
    do_reset();
    set_bins(11'd11, 11'd222, 11'h79C, 11'd1023);
    ng = 0;
    no = 0;
    req_vld = 4'hF;
    out_rdy = 1'b1;
    #1;
    for (int c = 0; c < 65; c++) begin
      if (req_rdy != 4'b0 && ng < 8) begin
        for (int b = 0; b < 4; b++) if (req_rdy[b]) g_id[ng] = b;
        g_cyc[ng] = c;
        ng++;
      end
      if (out_vld && no < 8) begin
        o_id[no] = int'(out_id);
        no++;
      end
      tick();
    end
    req_vld = '0;
    check("rr_grant_count", 32'(ng), 32'(5));
    check("rr_out_count", 32'(no), 32'(5));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_grant%0d", i), 32'(g_id[i]), 32'(exp_rr[i]));
      check($sformatf("rr_outid%0d", i), 32'(o_id[i]), 32'(exp_rr[i]));
      if (i > 0) check($sformatf("rr_gap%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'(13));
    end
    mptr = 0;
    #1;

    // Randomized jobs against the reference model.
    for (int j = 0; j < 25; j++) begin
      for (int r = 0; r < 4; r++) begin
        if ($urandom_range(0, 7) == 0) rb[r] = edge_vals[$urandom_range(0, 3)];
        else rb[r] = 11'($urandom);
      end
      set_bins(rb[0], rb[1], rb[2], rb[3]);
      rv = 4'($urandom_range(1, 15));
      w  = model_winner(rv);
      run_job(rv, ref_bcd(rb[w]), w, $urandom_range(0, 2), 4'b0,
              $sformatf("rnd%0d", j));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
